mult32_seq: RTL

Iterative 32x32 shift-add multiplier for the execute stage of the datapath. It accepts two 32-bit operands on a start pulse and produces a 64-bit product 33 cycles later. The low word feeds the writeback 2-way 32-bit select, alongside the ALU result; the high word is held for HI reads. A start/busy/done handshake lets the pipeline control stall while the unit iterates.

---
 rtl/mult32_seq.sv | 116 +++++++++++
 1 files changed

// File: rtl/mult32_seq.sv
// mult32_seq: iterative shift-add multiplier, 32x32 -> 64.
// A start in IDLE or DONE captures operand magnitudes and the product sign.
// Then 32 iteration cycles run, then one cycle fixes the sign and loads the result.
// done pulses 33 cycles after the start edge. The result registers hold until the next done.
module mult32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [PW-1:0]    mcand_q,  mcand_d;   // shifted multiplicand
  logic [WIDTH-1:0] mplier_q, mplier_d;  // multiplier, consumed LSB first
  logic [PW-1:0]    acc_q,    acc_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             last_q,   last_d;    // set once the final add has been done
  logic             neg_q,    neg_d;
  logic [PW-1:0]    res_q,    res_d;

  logic [WIDTH-1:0] mag_a, mag_b;

  // Operand magnitudes. The magnitude of the most negative value wraps to itself,
  // and that value is still correct when it is read as unsigned.
  always_comb begin
    mag_a = (is_signed && operand_a[WIDTH-1]) ? (~operand_a + WIDTH'(1)) : operand_a;
    mag_b = (is_signed && operand_b[WIDTH-1]) ? (~operand_b + WIDTH'(1)) : operand_b;
  end

  // Next-state logic for the FSM and the datapath.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    neg_d    = neg_q;
    res_d    = res_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = is_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          last_d   = 1'b0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        if (!last_q) begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) last_d = 1'b1;
        end else begin
          res_d   = neg_q ? (~acc_q + PW'(1)) : acc_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      neg_q    <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result_lo = res_q[WIDTH-1:0];
  assign result_hi = res_q[PW-1:WIDTH];

endmodule
